// File: rtl/sp_ram_arb2.sv
// Two-master round-robin arbiter in front of a single-port RAM with 1-cycle read latency.
// Grants are combinational from the requests; responses return to the owner one cycle later.
module sp_ram_arb2 #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  localparam int BE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [BE_WIDTH-1:0]   m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [BE_WIDTH-1:0]   m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [BE_WIDTH-1:0]   ram_be_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  logic prio_q, prio_d;
  logic resp_valid_q, resp_valid_d;
  logic resp_owner_q, resp_owner_d;
  logic resp_write_q, resp_write_d;
  logic gnt0_s, gnt1_s;

  // prio_q selects the winner only when both masters request
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (m0_req_i && m1_req_i) begin
      if (prio_q) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b1;
      end
    end else if (m0_req_i) begin
      gnt0_s = 1'b1;
    end else if (m1_req_i) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign m0_gnt_o = gnt0_s;
  assign m1_gnt_o = gnt1_s;

  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    case ({gnt1_s, gnt0_s})
      2'b01: begin
        ram_en_o    = 1'b1;
        ram_addr_o  = m0_addr_i;
        ram_we_o    = m0_we_i;
        ram_be_o    = m0_be_i;
        ram_wdata_o = m0_wdata_i;
      end
      2'b10: begin
        ram_en_o    = 1'b1;
        ram_addr_o  = m1_addr_i;
        ram_we_o    = m1_we_i;
        ram_be_o    = m1_be_i;
        ram_wdata_o = m1_wdata_i;
      end
      default: begin
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
      end
    endcase
  end

  always_comb begin
    prio_d       = prio_q;
    resp_valid_d = gnt0_s | gnt1_s;
    resp_owner_d = gnt1_s;
    resp_write_d = 1'b0;
    if (gnt0_s) begin
      prio_d       = 1'b1;
      resp_write_d = m0_we_i;
    end else if (gnt1_s) begin
      prio_d       = 1'b0;
      resp_write_d = m1_we_i;
    end else begin
      prio_d       = prio_q;
      resp_write_d = 1'b0;
    end
  end

  // Reset drops any pending response and restores m0 preference
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      prio_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_write_q <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      resp_write_q <= resp_write_d;
    end
  end

  assign m0_rvalid_o = resp_valid_q & ~resp_owner_q;
  assign m1_rvalid_o = resp_valid_q & resp_owner_q;

  always_comb begin
    m0_rdata_o = '0;
    m1_rdata_o = '0;
    if (resp_valid_q && !resp_write_q) begin
      if (resp_owner_q) begin
        m1_rdata_o = ram_rdata_i;
      end else begin
        m0_rdata_o = ram_rdata_i;
      end
    end else begin
      m0_rdata_o = '0;
      m1_rdata_o = '0;
    end
  end

endmodule
